// File: rtl/srp16_uart_pkg.sv
// Shared definitions for the SRP16 memory-mapped UART transmitter.
// Holds register word offsets, STATUS bit positions, the transmit FSM
// state encoding, parameter defaults and a baud-divider helper.
// Optional feature macro: SRP16_UART_PARITY_EN (even-parity bit, 8E1 frame).
package srp16_uart_pkg;

   // Register word offsets inside the 4-word window
   localparam logic [1:0] REG_TXDATA   = 2'd0;
   localparam logic [1:0] REG_STATUS   = 2'd1;
   localparam logic [1:0] REG_BAUDDIV  = 2'd2;
   localparam logic [1:0] REG_RESERVED = 2'd3;

   // STATUS register bit positions
   localparam int unsigned STAT_FULL    = 0;
   localparam int unsigned STAT_EMPTY   = 1;
   localparam int unsigned STAT_BUSY    = 2;
   localparam int unsigned STAT_CNT_LSB = 4;
   localparam int unsigned STAT_CNT_MSB = 7;

   // Parameter defaults
   localparam logic [15:0] BASE_ADDR_DEFAULT = 16'hFF00;
   localparam logic [15:0] DIV_RESET_DEFAULT = 16'd16;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } tx_state_e;

   // A divider of zero would never produce a bit boundary; run it as one.
   function automatic logic [15:0] eff_div(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/srp16_sync_fifo.sv
// Synchronous FIFO used as the UART transmit queue.
// Show-ahead read: rdata always presents the oldest entry, pop discards it.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset (pointers and count cleared)
//   push   in   write wdata into the FIFO
//   wdata  in   WIDTH-bit entry to store
//   pop    in   discard the oldest entry
//   rdata  out  oldest entry
//   full   out  FIFO holds DEPTH entries
//   empty  out  FIFO holds no entries
//   count  out  number of entries, $clog2(DEPTH)+1 bits
module srp16_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_MAX);
   assign pop_ok  = pop && !empty;
   // A pop in the same cycle frees the slot the push needs.
   assign push_ok = push && (!full || pop_ok);
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         if (push_ok && !pop_ok) begin
            count_q <= count_q + CNT_ONE;
         end else if (pop_ok && !push_ok) begin
            count_q <= count_q - CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/srp16_uart_tx_port.sv
// Memory-mapped UART transmitter responding to SRP16 core bus cycles.
// Bytes written to TXDATA queue in a FIFO and are sent LSB first on tx,
// framed 8N1 (or 8E1 when SRP16_UART_PARITY_EN is defined).
// Register window BASE_ADDR..BASE_ADDR+3:
//   +0 TXDATA (W)  +1 STATUS (R)  +2 BAUDDIV (R/W)  +3 reserved (reads 0)
// Ports:
//   clk          in     system clock
//   reset        in     asynchronous active-low reset
//   address_bus  in     core address
//   data_bus     inout  shared data bus, driven only during a decoded read
//   mem_read     in     core read strobe
//   mem_write    in     core write strobe
//   tx           out    serial output, idle high, registered
//   tx_idle      out    registered: FIFO empty and FSM idle
module srp16_uart_tx_port
   import srp16_uart_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR  = BASE_ADDR_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = DIV_RESET_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] address_bus,
   inout  wire  [15:0] data_bus,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic        tx,
   output logic        tx_idle
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   // Address decode and bus interface
   logic [15:0] offset;
   logic        in_win;
   logic [1:0]  reg_sel;
   logic        wr_en;
   logic        rd_en;
   logic [15:0] rd_data;
   logic [15:0] status;
   logic [3:0]  cnt_sat;

   // FIFO
   logic             fifo_push;
   logic             fifo_pop;
   logic [7:0]       fifo_rdata;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   // Transmit engine
   tx_state_e   state_q, state_d;
   logic [15:0] baud_div_q;
   logic [15:0] baud_cnt_q;
   logic [2:0]  bit_cnt_q;
   logic [7:0]  shift_q;
   logic        tx_q, tx_d;
   logic        tx_idle_q;
   logic        bit_tick;
   logic        bit_start;
`ifdef SRP16_UART_PARITY_EN
   logic        parity_q;
`endif

   // Subtracting the base keeps the decode correct for unaligned bases.
   assign offset  = address_bus - BASE_ADDR;
   assign in_win  = (offset < 16'd4);
   assign reg_sel = offset[1:0];
   assign wr_en   = mem_write && !mem_read && in_win;
   assign rd_en   = mem_read && in_win;

   assign fifo_push = wr_en && (reg_sel == REG_TXDATA);

   always_comb begin
      if (32'(fifo_count) > 32'd15) begin
         cnt_sat = 4'hF;
      end else begin
         cnt_sat = 4'(fifo_count);
      end
   end

   always_comb begin
      status                             = '0;
      status[STAT_FULL]                  = fifo_full;
      status[STAT_EMPTY]                 = fifo_empty;
      status[STAT_BUSY]                  = (state_q != StIdle);
      status[STAT_CNT_MSB:STAT_CNT_LSB]  = cnt_sat;
   end

   always_comb begin
      rd_data = '0;
      case (reg_sel)
         REG_STATUS:   rd_data = status;
         REG_BAUDDIV:  rd_data = baud_div_q;
         REG_TXDATA,
         REG_RESERVED: rd_data = '0;
         default:      rd_data = '0;
      endcase
   end

   assign data_bus = rd_en ? rd_data : 16'hzzzz;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         baud_div_q <= DIV_RESET;
      end else if (wr_en && (reg_sel == REG_BAUDDIV)) begin
         baud_div_q <= data_bus;
      end
   end

   srp16_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .wdata (data_bus[7:0]),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   assign bit_tick = (baud_cnt_q == 16'd0);

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) state_d = StStart;
         end
         StStart: begin
            if (bit_tick) state_d = StData;
         end
         StData: begin
            if (bit_tick && (bit_cnt_q == 3'd7)) begin
`ifdef SRP16_UART_PARITY_EN
               state_d = StParity;
`else
               state_d = StStop;
`endif
            end
         end
`ifdef SRP16_UART_PARITY_EN
         StParity: begin
            if (bit_tick) state_d = StStop;
         end
`endif
         StStop: begin
            // Chain straight into the next frame when a byte is waiting.
            if (bit_tick) state_d = fifo_empty ? StIdle : StStart;
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      fifo_pop = 1'b0;
      tx_d     = 1'b1;
      unique case (state_q)
         StIdle: begin
            fifo_pop = !fifo_empty;
         end
         StStart: begin
            tx_d = 1'b0;
         end
         StData: begin
            tx_d = shift_q[0];
         end
`ifdef SRP16_UART_PARITY_EN
         StParity: begin
            tx_d = parity_q;
         end
`endif
         StStop: begin
            tx_d     = 1'b1;
            fifo_pop = bit_tick && !fifo_empty;
         end
         default: begin
            tx_d = 1'b1;
         end
      endcase
   end

   // Reload the baud counter whenever a new bit begins; the divider is only
   // sampled here, so a BAUDDIV write lands on the next bit boundary.
   assign bit_start = (state_d != StIdle) && ((state_q == StIdle) || bit_tick);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         tx_idle_q  <= 1'b1;
`ifdef SRP16_UART_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         tx_q      <= tx_d;
         tx_idle_q <= fifo_empty && (state_q == StIdle);

         if (bit_start) begin
            baud_cnt_q <= eff_div(baud_div_q) - 16'd1;
         end else if (state_q != StIdle) begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
         end

         if (state_q != StData) begin
            bit_cnt_q <= '0;
         end else if (bit_tick) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
         end

         if (fifo_pop) begin
            shift_q <= fifo_rdata;
`ifdef SRP16_UART_PARITY_EN
            parity_q <= ^fifo_rdata;
`endif
         end else if ((state_q == StData) && bit_tick) begin
            shift_q <= shift_q >> 1;
         end
      end
   end

   assign tx      = tx_q;
   assign tx_idle = tx_idle_q;

endmodule

// File: tb/tb_srp16_uart_tx_port.sv
// Directed self-checking bench for srp16_uart_tx_port.
// Define SRP16_UART_PARITY_EN for both bench and RTL to check the 8E1 build.
module tb_srp16_uart_tx_port;

   localparam logic [15:0] BASE = 16'hFF00;
   // Pattern the bench holds on data_bus whenever it is not reading; it only
   // reads back unchanged if the port keeps its drivers off the bus.
   localparam logic [15:0] BG   = 16'h5A50;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] address_bus;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] tb_data;
   logic        tb_drive;
   wire  [15:0] data_bus;
   logic        tx;
   logic        tx_idle;

   int n_tests = 0;
   int n_fail  = 0;

   logic exp_q[$];
   logic cap_q[$];
   bit   cap_en = 1'b0;

   assign data_bus = tb_drive ? tb_data : 16'hzzzz;

   always #5 clk = ~clk;

   // tx sample taken 1 time unit after every rising edge
   always @(posedge clk) begin
      #1;
      if (cap_en) cap_q.push_back(tx);
   end

   srp16_uart_tx_port #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (8),
      .DIV_RESET  (16'd16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .address_bus (address_bus),
      .data_bus    (data_bus),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .tx          (tx),
      .tx_idle     (tx_idle)
   );

   // ---------------- bus and waveform utilities (no checking) ----------------
   // Called at a falling edge; returns at the next falling edge.
   task automatic bus_write(input logic [15:0] addr, input logic [15:0] d);
      address_bus = addr;
      tb_data     = d;
      tb_drive    = 1'b1;
      mem_write   = 1'b1;
      @(negedge clk);
      mem_write   = 1'b0;
      tb_data     = BG;
   endtask

   task automatic bus_read(input logic [15:0] addr, output logic [15:0] d);
      address_bus = addr;
      tb_drive    = 1'b0;
      mem_read    = 1'b1;
      #1;
      d           = data_bus;
      mem_read    = 1'b0;
      tb_drive    = 1'b1;
      #1;
   endtask

   task automatic add_level(input logic v, input int n);
      repeat (n) exp_q.push_back(v);
   endtask

   task automatic add_frame(input logic [7:0] b, input int div);
      add_level(1'b0, div);
      for (int i = 0; i < 8; i++) add_level(b[i], div);
`ifdef SRP16_UART_PARITY_EN
      add_level(^b, div);
`endif
      add_level(1'b1, div);
   endtask

   // Capture starts with the write edge, so two idle samples precede start.
   task automatic start_capture;
      cap_q.delete();
      exp_q.delete();
      add_level(1'b1, 2);
      cap_en = 1'b1;
   endtask

   task automatic finish_capture;
      repeat (exp_q.size()) @(negedge clk);
      cap_en = 1'b0;
   endtask

   function automatic int first_diff();
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i >= cap_q.size()) return i;
         if (cap_q[i] !== exp_q[i]) return i;
      end
      return -1;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset;
      logic [15:0] d;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (tx !== 1'b1) begin
         n_fail++; $display("FAIL reset_tx: got %b, required 1", tx);
      end
      n_tests++;
      if (tx_idle !== 1'b1) begin
         n_fail++; $display("FAIL reset_tx_idle: got %b, required 1", tx_idle);
      end
      reset = 1'b1;
      @(negedge clk);
      bus_read(BASE + 16'd1, d);
      n_tests++;
      if (d !== 16'h0002) begin
         n_fail++; $display("FAIL status_idle: got %h, required 0002", d);
      end
      bus_read(BASE + 16'd2, d);
      n_tests++;
      if (d !== 16'h0010) begin
         n_fail++; $display("FAIL bauddiv_reset: got %h, required 0010", d);
      end
      address_bus = 16'h0000;
      mem_read    = 1'b1;
      #1;
      n_tests++;
      if (data_bus !== BG) begin
         n_fail++; $display("FAIL read_outside_released: got %h, required %h", data_bus, BG);
      end
      mem_read    = 1'b0;
      address_bus = BASE + 16'd1;
      #1;
      n_tests++;
      if (data_bus !== BG) begin
         n_fail++; $display("FAIL no_strobe_released: got %h, required %h", data_bus, BG);
      end
      @(negedge clk);
   endtask

   task automatic test_bauddiv;
      logic [15:0] d;
      bus_write(BASE + 16'd2, 16'd4);
      bus_read(BASE + 16'd2, d);
      n_tests++;
      if (d !== 16'h0004) begin
         n_fail++; $display("FAIL bauddiv_rw: got %h, required 0004", d);
      end
      bus_write(BASE + 16'd3, 16'hBEEF);
      bus_read(BASE + 16'd3, d);
      n_tests++;
      if (d !== 16'h0000) begin
         n_fail++; $display("FAIL reserved_read: got %h, required 0000", d);
      end
      // BASE+4 is outside the window; BAUDDIV must not change
      bus_write(BASE + 16'd4, 16'd9);
      bus_read(BASE + 16'd2, d);
      n_tests++;
      if (d !== 16'h0004) begin
         n_fail++; $display("FAIL write_outside_ignored: got %h, required 0004", d);
      end
   endtask

   task automatic test_frame_55;
      logic [15:0] d;
      int bad;
      start_capture();
      add_frame(8'h55, 4);
      add_level(1'b1, 4);
      // upper byte of the bus must be ignored by TXDATA
      bus_write(BASE, 16'h1255);
      repeat (2) @(negedge clk);
      n_tests++;
      if (tx_idle !== 1'b0) begin
         n_fail++; $display("FAIL tx_idle_busy: got %b, required 0", tx_idle);
      end
      bus_read(BASE + 16'd1, d);
      n_tests++;
      if (d !== 16'h0006) begin
         n_fail++; $display("FAIL status_busy: got %h, required 0006", d);
      end
      finish_capture();
      bad = first_diff();
      n_tests++;
      if (bad != -1) begin
         n_fail++;
         $display("FAIL frame_55: sample %0d tx=%b, required %b", bad,
                  (bad < cap_q.size()) ? cap_q[bad] : 1'bx, exp_q[bad]);
      end
      n_tests++;
      if (tx_idle !== 1'b1) begin
         n_fail++; $display("FAIL tx_idle_after: got %b, required 1", tx_idle);
      end
   endtask

   task automatic test_back_to_back;
      int bad;
      start_capture();
      add_frame(8'h01, 4);
      add_frame(8'h80, 4);
      add_level(1'b1, 4);
      bus_write(BASE, 16'h0001);
      bus_write(BASE, 16'h0080);
      finish_capture();
      bad = first_diff();
      n_tests++;
      if (bad != -1) begin
         n_fail++;
         $display("FAIL back_to_back: sample %0d tx=%b, required %b", bad,
                  (bad < cap_q.size()) ? cap_q[bad] : 1'bx, exp_q[bad]);
      end
   endtask

   task automatic test_div_zero;
      logic [15:0] d;
      int bad;
      bus_write(BASE + 16'd2, 16'd0);
      bus_read(BASE + 16'd2, d);
      n_tests++;
      if (d !== 16'h0000) begin
         n_fail++; $display("FAIL bauddiv_zero_rd: got %h, required 0000", d);
      end
      start_capture();
      add_frame(8'hC6, 1);
      add_level(1'b1, 4);
      bus_write(BASE, 16'h00C6);
      finish_capture();
      bad = first_diff();
      n_tests++;
      if (bad != -1) begin
         n_fail++;
         $display("FAIL frame_div0: sample %0d tx=%b, required %b", bad,
                  (bad < cap_q.size()) ? cap_q[bad] : 1'bx, exp_q[bad]);
      end
   endtask

   task automatic test_fifo_full;
      logic [15:0] d;
      int bad;
      bus_write(BASE + 16'd2, 16'd2);
      start_capture();
      for (int i = 0; i < 9; i++) add_frame(8'h10 + 8'(i), 2);
      add_level(1'b1, 6);
      // first byte is popped one cycle after its write; the rest fill the FIFO
      for (int i = 0; i < 8; i++) bus_write(BASE, 16'h0010 + 16'(i));
      bus_read(BASE + 16'd1, d);
      n_tests++;
      if (d !== 16'h0074) begin
         n_fail++; $display("FAIL status_count7: got %h, required 0074", d);
      end
      bus_write(BASE, 16'h0018);
      bus_read(BASE + 16'd1, d);
      n_tests++;
      if (d !== 16'h0085) begin
         n_fail++; $display("FAIL status_full: got %h, required 0085", d);
      end
      bus_write(BASE, 16'h00EE);
      bus_read(BASE + 16'd1, d);
      n_tests++;
      if (d !== 16'h0085) begin
         n_fail++; $display("FAIL push_on_full_dropped: got %h, required 0085", d);
      end
      finish_capture();
      bad = first_diff();
      n_tests++;
      if (bad != -1) begin
         n_fail++;
         $display("FAIL fifo_frames: sample %0d tx=%b, required %b", bad,
                  (bad < cap_q.size()) ? cap_q[bad] : 1'bx, exp_q[bad]);
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] d;
      bus_write(BASE + 16'd2, 16'd4);
      bus_write(BASE, 16'h00A3);
      bus_write(BASE, 16'h003C);
      // now one cycle after the second write; data bit 2 (a 0) is on tx 16 later
      repeat (16) @(negedge clk);
      n_tests++;
      if (tx !== 1'b0) begin
         n_fail++; $display("FAIL mid_frame_bit2: got %b, required 0", tx);
      end
      reset = 1'b0;
      #1;
      n_tests++;
      if (tx !== 1'b1) begin
         n_fail++; $display("FAIL async_reset_tx: got %b, required 1", tx);
      end
      n_tests++;
      if (tx_idle !== 1'b1) begin
         n_fail++; $display("FAIL async_reset_idle: got %b, required 1", tx_idle);
      end
      @(negedge clk);
      reset = 1'b1;
      bus_read(BASE + 16'd1, d);
      n_tests++;
      if (d !== 16'h0002) begin
         n_fail++; $display("FAIL status_after_reset: got %h, required 0002", d);
      end
      bus_read(BASE + 16'd2, d);
      n_tests++;
      if (d !== 16'h0010) begin
         n_fail++; $display("FAIL bauddiv_after_reset: got %h, required 0010", d);
      end
      repeat (40) @(negedge clk);
      n_tests++;
      if (tx !== 1'b1 || tx_idle !== 1'b1) begin
         n_fail++; $display("FAIL queued_lost: got tx=%b idle=%b, required 1 1", tx, tx_idle);
      end
   endtask

`ifdef SRP16_UART_PARITY_EN
   task automatic test_parity;
      int bad;
      bus_write(BASE + 16'd2, 16'd4);
      start_capture();
      add_frame(8'h07, 4);
      add_level(1'b1, 4);
      bus_write(BASE, 16'h0007);
      finish_capture();
      bad = first_diff();
      n_tests++;
      if (bad != -1 || exp_q[2 + 36] !== 1'b1) begin
         n_fail++;
         $display("FAIL parity_07: sample %0d tx=%b, required %b", bad,
                  (bad >= 0 && bad < cap_q.size()) ? cap_q[bad] : 1'bx,
                  (bad >= 0) ? exp_q[bad] : 1'bx);
      end
      start_capture();
      add_frame(8'h03, 4);
      add_level(1'b1, 4);
      bus_write(BASE, 16'h0003);
      finish_capture();
      bad = first_diff();
      n_tests++;
      if (bad != -1) begin
         n_fail++;
         $display("FAIL parity_03: sample %0d tx=%b, required %b", bad,
                  (bad < cap_q.size()) ? cap_q[bad] : 1'bx, exp_q[bad]);
      end
   endtask
`endif

   initial begin
      reset       = 1'b0;
      address_bus = 16'h0000;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      tb_data     = BG;
      tb_drive    = 1'b1;
      @(negedge clk);
      test_reset();
      test_bauddiv();
      test_frame_55();
      test_back_to_back();
      test_div_zero();
      test_fifo_full();
      test_reset_mid();
`ifdef SRP16_UART_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
